// File: rtl/rr_sel_pkg.sv
// Shared definitions for the rr_sel_arbiter_4 round-robin mux-select arbiter:
// channel count, select width, FSM state encoding and the one-hot decode.
package rr_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot decode of a channel index into a grant vector.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_CH'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotate-priority picker: returns the first requesting channel
// found when scanning start, start+1, start+2, start+3 (mod 4).
module rr_pick_4
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  win,
  output logic              any
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest to nearest so the channel closest to start wins last.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter_4.sv
// Round-robin arbiter driving the registered 2-bit select of a 4:1 mux.
// A grant is held until its requester drops or HOLD_MAX cycles elapse; the
// releasing channel is searched last so all active requesters get a turn.
// Optional feature: define RR_SEL_LOCK_EN to add a lock input that
// suppresses the hold-timeout release while a grant is active.
module rr_sel_arbiter_4
  import rr_sel_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
`ifdef RR_SEL_LOCK_EN
  input  logic              lock,
`endif
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              valid,
  output logic [CNT_W-1:0]  hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t            state, state_nx;
  logic [SEL_W-1:0]  ptr, ptr_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [NUM_CH-1:0] grant_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic [SEL_W-1:0]  pick_start;
  logic [SEL_W-1:0]  pick_win;
  logic              pick_any;
  logic              hold_lock;
  logic              timeout;
  logic              release_now;

`ifdef RR_SEL_LOCK_EN
  assign hold_lock = lock & valid;
`else
  assign hold_lock = 1'b0;
`endif

  assign valid       = (state == ST_GRANT);
  assign timeout     = (hold_cnt == HOLD_LAST) & ~hold_lock;
  assign release_now = ~req[sel] | timeout;

  // While granting, the next search begins just past the current holder so
  // it is considered last; from idle it begins at the stored pointer.
  assign pick_start = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;

  rr_pick_4 u_pick (
    .req   (req),
    .start (pick_start),
    .win   (pick_win),
    .any   (pick_any)
  );

  // State register and registered outputs; reset overrides any active grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      sel      <= '0;
      grant    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      sel      <= sel_nx;
      grant    <= grant_nx;
      hold_cnt <= cnt_nx;
    end
  end

  // Next-state logic: grant from idle, hold with saturating count, hand off.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    grant_nx = grant;
    cnt_nx   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          sel_nx   = pick_win;
          grant_nx = sel_onehot(pick_win);
          cnt_nx   = '0;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_nx = sel + SEL_W'(1);
          cnt_nx = '0;
          if (pick_any) begin
            sel_nx   = pick_win;
            grant_nx = sel_onehot(pick_win);
          end else begin
            grant_nx = '0;
            state_nx = ST_IDLE;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_sel_arbiter_4.sv
// Directed bench for rr_sel_arbiter_4: one instance with HOLD_MAX=8 and one
// with HOLD_MAX=1, sharing clock and reset. Lock checks appear when
// RR_SEL_LOCK_EN is defined.
module tb_rr_sel_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, req1;
  logic [1:0] sel8, sel1;
  logic [3:0] grant8, grant1;
  logic       valid8, valid1;
  logic [7:0] cnt8, cnt1;
`ifdef RR_SEL_LOCK_EN
  logic       lock8, lock1;
`endif

  int checks = 0;
  int errors = 0;

  rr_sel_arbiter_4 #(.HOLD_MAX(8), .CNT_W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req8),
`ifdef RR_SEL_LOCK_EN
    .lock     (lock8),
`endif
    .sel      (sel8),
    .grant    (grant8),
    .valid    (valid8),
    .hold_cnt (cnt8)
  );

  rr_sel_arbiter_4 #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req1),
`ifdef RR_SEL_LOCK_EN
    .lock     (lock1),
`endif
    .sel      (sel1),
    .grant    (grant1),
    .valid    (valid1),
    .hold_cnt (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic [7:0] c);
    chk({tag, "_grant"}, 32'(grant8), 32'(g));
    chk({tag, "_sel"},   32'(sel8),   32'(s));
    chk({tag, "_valid"}, 32'(valid8), 32'(v));
    chk({tag, "_cnt"},   32'(cnt8),   32'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    req8  = 4'b0000;
    req1  = 4'b0000;
`ifdef RR_SEL_LOCK_EN
    lock8 = 1'b0;
    lock1 = 1'b0;
`endif

    // Reset state
    step();
    step();
    chk8("reset", 4'b0000, 2'd0, 1'b0, 8'd0);
    chk("reset_dut1_valid", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    step();
    chk8("idle_noreq", 4'b0000, 2'd0, 1'b0, 8'd0);

    // Single requester on ch1
    req8 = 4'b0010;
    step();
    chk8("single_grant", 4'b0010, 2'd1, 1'b1, 8'd0);
    step(); step(); step();
    chk8("single_cnt3", 4'b0010, 2'd1, 1'b1, 8'd3);
    req8 = 4'b0000;
    step();
    chk8("single_drop", 4'b0000, 2'd1, 1'b0, 8'd0);

    // Pointer now 2: 1001 picks ch3 first, then hands off to ch0 with no bubble
    req8 = 4'b1001;
    step();
    chk8("b2b_ch3", 4'b1000, 2'd3, 1'b1, 8'd0);
    req8 = 4'b0001;
    step();
    chk8("b2b_to_ch0", 4'b0001, 2'd0, 1'b1, 8'd0);
    req8 = 4'b1001;
    step();
    chk8("b2b_hold_ch0", 4'b0001, 2'd0, 1'b1, 8'd1);
    req8 = 4'b1000;
    step();
    chk8("b2b_to_ch3", 4'b1000, 2'd3, 1'b1, 8'd0);
    req8 = 4'b0000;
    step();
    chk8("b2b_idle", 4'b0000, 2'd3, 1'b0, 8'd0);

    // Pointer wrapped to 0: all requesting rotates 0,1,2,3,0 for 8 cycles each
    req8 = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_sel",   32'(sel8),   32'(g % 4));
        chk("rr_grant", 32'(grant8), 32'(1) << (g % 4));
        chk("rr_valid", 32'(valid8), 32'd1);
        chk("rr_cnt",   32'(cnt8),   32'(k));
        step();
      end
    end
    chk8("rr_next_ch1", 4'b0010, 2'd1, 1'b1, 8'd0);
    req8 = 4'b0000;
    step();
    chk8("rr_idle", 4'b0000, 2'd1, 1'b0, 8'd0);

    // Pointer 2: ch2 alone times out and is re-granted with a fresh count
    req8 = 4'b0100;
    step();
    chk8("sole_grant", 4'b0100, 2'd2, 1'b1, 8'd0);
    repeat (7) step();
    chk8("sole_cnt7", 4'b0100, 2'd2, 1'b1, 8'd7);
    step();
    chk8("sole_regrant", 4'b0100, 2'd2, 1'b1, 8'd0);
    req8 = 4'b0011;
    step();
    chk8("wrap_to_ch0", 4'b0001, 2'd0, 1'b1, 8'd0);
    req8 = 4'b0000;
    step();
    chk8("wrap_idle", 4'b0000, 2'd0, 1'b0, 8'd0);

    // Reset mid-grant (pointer 1, so 0100 grants ch2)
    req8 = 4'b0100;
    step();
    chk8("rst_pre", 4'b0100, 2'd2, 1'b1, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("rst_async", 4'b0000, 2'd0, 1'b0, 8'd0);
    req8 = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk8("rst_after", 4'b0000, 2'd0, 1'b0, 8'd0);

    // HOLD_MAX=1: strict one-cycle rotation
    req1 = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("h1_sel",   32'(sel1),   32'(i % 4));
      chk("h1_grant", 32'(grant1), 32'(1) << (i % 4));
      chk("h1_valid", 32'(valid1), 32'd1);
      chk("h1_cnt",   32'(cnt1),   32'd0);
    end
    req1 = 4'b0000;
    step();
    chk("h1_idle", 32'(valid1), 32'd0);

`ifdef RR_SEL_LOCK_EN
    // Lock holds ch0 past the timeout; clearing it hands off to ch1
    req8  = 4'b0011;
    lock8 = 1'b1;
    step();
    chk8("lock_grant", 4'b0001, 2'd0, 1'b1, 8'd0);
    repeat (15) step();
    chk8("lock_held", 4'b0001, 2'd0, 1'b1, 8'd7);
    lock8 = 1'b0;
    step();
    chk8("lock_release", 4'b0010, 2'd1, 1'b1, 8'd0);
    req8 = 4'b0000;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
